// File: rtl/mac_gate_ctrl.sv
// -----------------------------------------------------------------------------
// mac_gate_ctrl
//
// Operand-isolation controller placed directly upstream of the MAC gating
// latches. It turns an activation/weight beat stream into latch enables:
//   * weights latch only when a load_w beat arrives,
//   * activations latch only when the resulting product is non-zero,
//   * zero products are flagged (zero_skip) so the MAC adds 0 while its
//     operand latches stay frozen.
// After IDLE_CYC consecutive empty cycles in RUN the controller returns to
// IDLE. All outputs are registered, so a beat sampled at edge N shows up
// right after edge N. There is no backpressure, so one beat is accepted
// every cycle.
//
// Optional build macro: MAC_GATE_STATS_EN
//   defined   -> saturating 16-bit counters of issued and skipped products.
//                clr_cnt clears both counters and wins over an increment.
//   undefined -> cnt_active and cnt_skip are tied to 0 and clr_cnt is ignored.
//
// Parameters
//   bw        operand width (signed)
//   IDLE_CYC  empty RUN cycles before the return to IDLE (1..255)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   valid_in   input beat valid
//   load_w     with valid_in: the beat carries a new weight (act_in ignored)
//   act_in     signed activation
//   wgt_in     signed weight
//   clr_cnt    synchronous statistics clear
//   act_en     activation latch enable (single-cycle pulse)
//   act_q      activation presented to the latch; changes only with act_en
//   wgt_en     weight latch enable (single-cycle pulse)
//   wgt_q      weight presented to the latch; changes only with wgt_en
//   mac_valid  downstream MAC performs one accumulate this cycle
//   zero_skip  the accumulate must add 0; operands are held
//   busy       controller is not in IDLE
//   cnt_active non-zero products issued
//   cnt_skip   zero products skipped
// -----------------------------------------------------------------------------
module mac_gate_ctrl #(
    parameter int bw       = 8,
    parameter int IDLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic                 load_w,
    input  logic signed [bw-1:0] act_in,
    input  logic signed [bw-1:0] wgt_in,
    input  logic                 clr_cnt,
    output logic                 act_en,
    output logic signed [bw-1:0] act_q,
    output logic                 wgt_en,
    output logic signed [bw-1:0] wgt_q,
    output logic                 mac_valid,
    output logic                 zero_skip,
    output logic                 busy,
    output logic [15:0]          cnt_active,
    output logic [15:0]          cnt_skip
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WLOAD = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Terminal value of the empty-cycle counter: reaching it on an empty
    // cycle means this is the IDLE_CYC-th consecutive empty RUN cycle.
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYC - 1);

    state_t                state_reg, state_next;
    logic [7:0]            idle_cnt_reg, idle_cnt_next;
    logic signed [bw-1:0]  wgt_reg, wgt_next;
    logic signed [bw-1:0]  act_q_reg, act_q_next;
    logic                  act_en_reg, act_en_next;
    logic                  wgt_en_reg, wgt_en_next;
    logic                  mac_valid_reg, mac_valid_next;
    logic                  zero_skip_reg, zero_skip_next;
    logic                  prod_zero;

    // The product is zero whenever either operand is zero. The weight used
    // is the stored one, which already holds a weight loaded on the
    // previous edge, so a beat in the WLOAD cycle sees the new weight.
    assign prod_zero = (act_in == '0) || (wgt_reg == '0);

    always_comb begin
        state_next     = state_reg;
        idle_cnt_next  = idle_cnt_reg;
        wgt_next       = wgt_reg;
        act_q_next     = act_q_reg;
        act_en_next    = 1'b0;
        wgt_en_next    = 1'b0;
        mac_valid_next = 1'b0;
        zero_skip_next = 1'b0;

        // A beat is handled the same way in every state. IDLE moves
        // straight into RUN (or WLOAD) and processes the beat, and a beat
        // during WLOAD follows RUN rules, so no bubble is inserted.
        if (valid_in && load_w) begin
            wgt_next      = wgt_in;
            wgt_en_next   = 1'b1;
            state_next    = WLOAD;
            idle_cnt_next = '0;
        end else if (valid_in) begin
            mac_valid_next = 1'b1;
            state_next     = RUN;
            idle_cnt_next  = '0;
            if (prod_zero) begin
                zero_skip_next = 1'b1;
            end else begin
                act_en_next = 1'b1;
                act_q_next  = act_in;
            end
        end else begin
            case (state_reg)
                WLOAD: begin
                    state_next    = RUN;
                    idle_cnt_next = '0;
                end
                RUN: begin
                    if (idle_cnt_reg == IDLE_LAST) begin
                        state_next    = IDLE;
                        idle_cnt_next = '0;
                    end else begin
                        idle_cnt_next = idle_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    // IDLE holds. The unused encoding recovers to IDLE.
                    state_next    = IDLE;
                    idle_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            idle_cnt_reg  <= '0;
            wgt_reg       <= '0;
            act_q_reg     <= '0;
            act_en_reg    <= 1'b0;
            wgt_en_reg    <= 1'b0;
            mac_valid_reg <= 1'b0;
            zero_skip_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idle_cnt_reg  <= idle_cnt_next;
            wgt_reg       <= wgt_next;
            act_q_reg     <= act_q_next;
            act_en_reg    <= act_en_next;
            wgt_en_reg    <= wgt_en_next;
            mac_valid_reg <= mac_valid_next;
            zero_skip_reg <= zero_skip_next;
        end
    end

    // The stored weight only changes on a load, which is exactly when
    // wgt_en pulses, so it can drive the weight latch input directly.
    assign wgt_q     = wgt_reg;
    assign act_q     = act_q_reg;
    assign act_en    = act_en_reg;
    assign wgt_en    = wgt_en_reg;
    assign mac_valid = mac_valid_reg;
    assign zero_skip = zero_skip_reg;
    assign busy      = (state_reg != IDLE);

`ifdef MAC_GATE_STATS_EN
    // Index 0 counts issued (non-zero) products and index 1 counts skipped
    // ones. Both use the same saturating structure.
    logic [1:0] cnt_inc;
    assign cnt_inc = {zero_skip_next, act_en_next};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [15:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (reset || clr_cnt) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign cnt_active = g_cnt[0].cnt_reg;
    assign cnt_skip   = g_cnt[1].cnt_reg;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign cnt_active     = '0;
    assign cnt_skip       = '0;
`endif

endmodule

// File: tb/tb_mac_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mac_gate_ctrl
//
// Scoreboard bench for mac_gate_ctrl. The stimulus task drives one cycle of
// inputs. It evaluates a behavioural model of the controller for that cycle
// and pushes the expected registered outputs into a queue. A separate
// monitor samples the DUT on every falling edge, pops the matching entry
// and compares it with the DUT outputs. Directed scenarios are followed by
// randomised traffic.
// -----------------------------------------------------------------------------
module tb_mac_gate_ctrl;

    localparam int BW   = 8;
    localparam int IDLE = 4;

    logic                 clk = 1'b0;
    logic                 reset, valid_in, load_w, clr_cnt;
    logic signed [BW-1:0] act_in, wgt_in;
    logic                 act_en, wgt_en, mac_valid, zero_skip, busy;
    logic signed [BW-1:0] act_q, wgt_q;
    logic [15:0]          cnt_active, cnt_skip;

    mac_gate_ctrl #(.bw(BW), .IDLE_CYC(IDLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .load_w     (load_w),
        .act_in     (act_in),
        .wgt_in     (wgt_in),
        .clr_cnt    (clr_cnt),
        .act_en     (act_en),
        .act_q      (act_q),
        .wgt_en     (wgt_en),
        .wgt_q      (wgt_q),
        .mac_valid  (mac_valid),
        .zero_skip  (zero_skip),
        .busy       (busy),
        .cnt_active (cnt_active),
        .cnt_skip   (cnt_skip)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        act_en;
        logic [7:0]  act_q;
        logic        wgt_en;
        logic [7:0]  wgt_q;
        logic        mac_valid;
        logic        zero_skip;
        logic        busy;
        logic [15:0] cnt_a;
        logic [15:0] cnt_s;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Reference model: the controller reduced to "current weight, last
    // latched activation, whether it is active, how long it has been empty".
    int m_wgt = 0, m_act = 0, m_ca = 0, m_cs = 0;
    int m_empty = 0;
    bit m_active = 0, m_just_loaded = 0;

    task automatic step(input logic v, input logic l, input int a, input int w,
                        input logic clr, input logic rst);
        exp_t e;
        valid_in = v;
        load_w   = l;
        act_in   = a[7:0];
        wgt_in   = w[7:0];
        clr_cnt  = clr;
        reset    = rst;
        e = '0;
        if (rst) begin
            m_wgt = 0; m_act = 0; m_ca = 0; m_cs = 0;
            m_empty = 0; m_active = 0; m_just_loaded = 0;
        end else begin
            if (v && l) begin
                m_wgt = w;
                e.wgt_en = 1'b1;
                m_active = 1; m_just_loaded = 1; m_empty = 0;
            end else if (v) begin
                e.mac_valid = 1'b1;
                m_active = 1; m_just_loaded = 0; m_empty = 0;
                if (a == 0 || m_wgt == 0) begin
                    e.zero_skip = 1'b1;
                    if (m_cs < 65535) m_cs++;
                end else begin
                    e.act_en = 1'b1;
                    m_act = a;
                    if (m_ca < 65535) m_ca++;
                end
            end else if (m_just_loaded) begin
                m_just_loaded = 0;
            end else if (m_active) begin
                m_empty++;
                if (m_empty == IDLE) begin
                    m_active = 0;
                    m_empty  = 0;
                end
            end
            if (clr) begin
                m_ca = 0;
                m_cs = 0;
            end
        end
        e.act_q = m_act[7:0];
        e.wgt_q = m_wgt[7:0];
        e.busy  = m_active;
`ifdef MAC_GATE_STATS_EN
        e.cnt_a = m_ca[15:0];
        e.cnt_s = m_cs[15:0];
`endif
        exp_q.push_back(e);
        tag_q.push_back(phase);
        @(posedge clk);
        #1;
    endtask

    // Monitor: the registered outputs are presented every cycle, one queue
    // entry per clock edge.
    always @(negedge clk) begin
        exp_t  e;
        exp_t  got;
        string t;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            got = {act_en, act_q, wgt_en, wgt_q, mac_valid, zero_skip, busy,
                   cnt_active, cnt_skip};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s t=%0t: got act_en=%b act_q=%0d wgt_en=%b wgt_q=%0d mv=%b zs=%b busy=%b ca=%0d cs=%0d | exp act_en=%b act_q=%0d wgt_en=%b wgt_q=%0d mv=%b zs=%b busy=%b ca=%0d cs=%0d",
                         t, $time, got.act_en, $signed(got.act_q), got.wgt_en,
                         $signed(got.wgt_q), got.mac_valid, got.zero_skip,
                         got.busy, got.cnt_a, got.cnt_s, e.act_en,
                         $signed(e.act_q), e.wgt_en, $signed(e.wgt_q),
                         e.mac_valid, e.zero_skip, e.busy, e.cnt_a, e.cnt_s);
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int a, w;
        bit v, l, c, r;

        phase = "reset_init";
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Two-cycle reset in the middle of RUN, with a beat pending during it.
        phase = "reset_mid_run";
        step(1, 1, 0, 5, 0, 0);
        step(1, 0, 3, 0, 0, 0);
        step(1, 0, 4, 0, 0, 0);
        step(1, 0, 6, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 5, 0, 0, 0);
        idle_cycles(IDLE + 1);

        phase = "load3_acts";
        step(1, 1, 0, 3, 0, 0);
        step(1, 0, 2, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, -4, 0, 0, 0);

        phase = "timeout_4";
        idle_cycles(4);
        phase = "timeout_3_then_beat";
        step(1, 0, 1, 0, 0, 0);
        idle_cycles(3);
        step(1, 0, 7, 0, 0, 0);
        idle_cycles(5);

        phase = "no_bubble";
        step(1, 1, 0, 7, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 9, 0, 0, 0);

        phase = "b2b_load";
        step(1, 1, 0, 1, 0, 0);
        step(1, 1, 0, 2, 0, 0);
        idle_cycles(2);
        step(1, 0, -1, 0, 0, 0);
        idle_cycles(6);

`ifdef MAC_GATE_STATS_EN
        phase = "stats_saturate";
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 70000; i++) step(1, 0, 3, 0, 0, 0);
        phase = "stats_clear";
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 5, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
`else
        phase = "stats_off";
        step(1, 0, 3, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0);
`endif

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 8 : 2));
            l = ($urandom_range(0, 4) == 0);
            a = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
            w = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
            c = ($urandom_range(0, 49) == 0);
            r = ($urandom_range(0, 199) == 0);
            step(v, l, a, w, c, r);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
